// File: rtl/tt_spine_sel_ctrl_pkg.sv
// Shared definitions for the spine selection controller: address width, FSM
// states and the sel-bus field layout that the row muxes decode.
package tt_spine_sel_ctrl_pkg;

    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    // Row-mux decode: branch = {sel[9:6], sel[4]}, bus = {sel[3:0], sel[5]}
    localparam int BRANCH_HI  = 9;
    localparam int BRANCH_LO  = 6;
    localparam int BRANCH_BIT = 4;
    localparam int BUS_HI     = 3;
    localparam int BUS_LO     = 0;
    localparam int BUS_BIT    = 5;

    function automatic logic [4:0] sel_branch(input logic [ADDR_W-1:0] sel);
        return {sel[BRANCH_HI:BRANCH_LO], sel[BRANCH_BIT]};
    endfunction

    function automatic logic [4:0] sel_bus(input logic [ADDR_W-1:0] sel);
        return {sel[BUS_HI:BUS_LO], sel[BUS_BIT]};
    endfunction

endpackage

// File: rtl/tt_spine_sel_ctrl_sync_edge.sv
// tt_sync_edge: pad synchroniser with reset preset and rising-edge pulse.
// Optional level debounce when TT_SEL_INC_DEBOUNCE_EN is defined (DEB_CYC > 0).
module tt_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0,
    parameter int   DEB_CYC     = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pad,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_sync;
    logic                   w_level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef TT_SEL_INC_DEBOUNCE_EN
    if (DEB_CYC > 0) begin : g_deb
        logic       r_deb;
        logic [7:0] r_deb_cnt;

        // Down-counter reloads whenever the input agrees with the filtered level
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_deb     <= RST_VAL;
                r_deb_cnt <= 8'(DEB_CYC - 1);
            end else if (w_sync == r_deb) begin
                r_deb_cnt <= 8'(DEB_CYC - 1);
            end else if (r_deb_cnt == 8'd0) begin
                r_deb     <= w_sync;
                r_deb_cnt <= 8'(DEB_CYC - 1);
            end else begin
                r_deb_cnt <= r_deb_cnt - 8'd1;
            end
        end

        assign w_level = r_deb;
    end else begin : g_nodeb
        assign w_level = w_sync;
    end
`else
    logic [7:0] w_deb_cyc_unused;
    assign w_deb_cyc_unused = 8'(DEB_CYC);
    assign w_level          = w_sync;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev <= RST_VAL;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;

endmodule

// File: rtl/tt_spine_sel_ctrl.sv
// Spine-side row-mux selection driver: synchronised pads, address counter and
// break-before-make enable FSM. Optional inc debounce: TT_SEL_INC_DEBOUNCE_EN.
//
// state  | meaning
// IDLE   | spine_ena low, waiting for requested enable
// SETTLE | address just changed, spine_ena held low for SETTLE_CYC cycles
// ACTIVE | spine_ena high on the selected design
module tt_spine_sel_ctrl
    import tt_spine_sel_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 8,
    parameter int ADDR_MAX    = 1023,
    parameter int DEB_CYC     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pad_sel_rst_n,
    input  logic              pad_sel_inc,
    input  logic              pad_sel_ena,
    output logic [ADDR_W-1:0] spine_sel,
    output logic              spine_ena,
    output logic              busy
);

    localparam int              SYNC_N      = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ADDR_MAX);

    logic w_s_rst_n, w_rst_rise_unused;
    logic w_inc_level_unused, w_inc_pulse;
    logic w_s_ena, w_ena_rise_unused;

    tt_sync_edge #(.SYNC_STAGES(SYNC_N), .RST_VAL(1'b1), .DEB_CYC(0)) u_sync_rst (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pad   (pad_sel_rst_n),
        .o_level (w_s_rst_n),
        .o_rise  (w_rst_rise_unused)
    );

    tt_sync_edge #(.SYNC_STAGES(SYNC_N), .RST_VAL(1'b0), .DEB_CYC(DEB_CYC)) u_sync_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pad   (pad_sel_inc),
        .o_level (w_inc_level_unused),
        .o_rise  (w_inc_pulse)
    );

    tt_sync_edge #(.SYNC_STAGES(SYNC_N), .RST_VAL(1'b0), .DEB_CYC(0)) u_sync_ena (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pad   (pad_sel_ena),
        .o_level (w_s_ena),
        .o_rise  (w_ena_rise_unused)
    );

    logic [ADDR_W-1:0] r_addr;
    logic              w_addr_chg;

    // Clearing an already-zero counter leaves the spine untouched, so no settle
    assign w_addr_chg = w_s_rst_n ? w_inc_pulse : (r_addr != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (!w_s_rst_n) begin
            r_addr <= '0;
        end else if (w_inc_pulse) begin
            r_addr <= (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
        end
    end

    state_e     r_state, w_state_nxt;
    logic [7:0] r_settle_cnt;
    logic       r_ena, r_busy;
    logic       w_ena_nxt, w_busy_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_settle_cnt <= 8'd0;
            r_ena        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ena   <= w_ena_nxt;
            r_busy  <= w_busy_nxt;
            if (w_addr_chg) begin
                r_settle_cnt <= SETTLE_LAST;
            end else if (r_state == SETTLE && r_settle_cnt != 8'd0) begin
                r_settle_cnt <= r_settle_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_addr_chg) begin
            w_state_nxt = SETTLE;
        end else begin
            case (r_state)
                IDLE:    if (w_s_ena) w_state_nxt = ACTIVE;
                SETTLE:  if (r_settle_cnt == 8'd0) w_state_nxt = w_s_ena ? ACTIVE : IDLE;
                ACTIVE:  if (!w_s_ena) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register alongside it
    always_comb begin
        w_ena_nxt  = (w_state_nxt == ACTIVE);
        w_busy_nxt = (w_state_nxt == SETTLE);
    end

    assign spine_sel = r_addr;
    assign spine_ena = r_ena;
    assign busy      = r_busy;

endmodule

// File: tb/tb_tt_spine_sel_ctrl.sv
// Scoreboard bench for tt_spine_sel_ctrl: stimulus queues expected output
// transitions with their cycle stamps, a monitor checks every DUT output change.
module tb_tt_spine_sel_ctrl;
    import tt_spine_sel_ctrl_pkg::*;

`ifdef TT_SEL_INC_DEBOUNCE_EN
    localparam int DEB = 4;
`else
    localparam int DEB = 0;
`endif
    localparam int LAT     = 3 + DEB;
    localparam int ENA_LAT = 3;
    localparam int SETTLE  = 8;
    localparam int FH      = (DEB > 0) ? DEB : 1;
    localparam int R_HI    = (DEB > 0) ? DEB : 2;
    localparam int R_LO    = (DEB > 0) ? DEB : 1;
    localparam int R_GAP   = R_HI + R_LO;

    logic              clk;
    logic              rst_n;
    logic              pad_sel_rst_n;
    logic              pad_sel_inc;
    logic              pad_sel_ena;
    logic [ADDR_W-1:0] spine_sel;
    logic              spine_ena;
    logic              busy;

    tt_spine_sel_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pad_sel_rst_n (pad_sel_rst_n),
        .pad_sel_inc   (pad_sel_inc),
        .pad_sel_ena   (pad_sel_ena),
        .spine_sel     (spine_sel),
        .spine_ena     (spine_ena),
        .busy          (busy)
    );

    typedef struct {
        logic [ADDR_W-1:0] sel;
        logic              ena;
        logic              bsy;
        int                cyc;
    } ev_t;

    ev_t q[$];
    int  compared   = 0;
    int  mismatched = 0;
    int  cyc        = 0;
    int  m_sel      = 0;
    bit  mon_en     = 1'b0;

    logic [ADDR_W-1:0] p_sel;
    logic              p_ena, p_bsy;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic push_ev(input int s, input logic e, input logic b, input int c);
        ev_t ev;
        ev.sel = ADDR_W'(s);
        ev.ena = e;
        ev.bsy = b;
        ev.cyc = c;
        q.push_back(ev);
    endtask

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && (spine_sel !== p_sel || spine_ena !== p_ena || busy !== p_bsy)) begin
            if (spine_sel !== p_sel) begin
                compared++;
                if (spine_ena !== 1'b0) begin
                    mismatched++;
                    $display("FAIL ena_on_sel_change: sel %0d->%0d with ena=%0b @%0d",
                             p_sel, spine_sel, spine_ena, cyc);
                end
            end
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_event: got sel=%0d ena=%0b busy=%0b @%0d, want none",
                         spine_sel, spine_ena, busy, cyc);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (spine_sel !== e.sel || spine_ena !== e.ena || busy !== e.bsy || cyc != e.cyc) begin
                    mismatched++;
                    $display("FAIL event: got sel=%0d ena=%0b busy=%0b @%0d, want sel=%0d ena=%0b busy=%0b @%0d",
                             spine_sel, spine_ena, busy, cyc, e.sel, e.ena, e.bsy, e.cyc);
                end
            end
            p_sel = spine_sel;
            p_ena = spine_ena;
            p_bsy = busy;
        end
    end

    task automatic drive_inc(input int hi, input int lo);
        pad_sel_inc = 1'b1;
        repeat (hi) @(negedge clk);
        pad_sel_inc = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic step_clean();
        int n;
        n = cyc;
        m_sel = (m_sel == 1023) ? 0 : m_sel + 1;
        push_ev(m_sel, 1'b0, 1'b1, n + LAT);
        push_ev(m_sel, 1'b1, 1'b0, n + LAT + SETTLE);
        drive_inc(6, 6);
    endtask

    task automatic fast_incs(input int count);
        int n;
        n = cyc;
        for (int i = 0; i < count; i++) begin
            n = cyc;
            m_sel = (m_sel == 1023) ? 0 : m_sel + 1;
            push_ev(m_sel, 1'b0, 1'b1, n + LAT);
            drive_inc(FH, FH);
        end
        push_ev(m_sel, 1'b1, 1'b0, n + LAT + SETTLE);
        repeat (LAT + SETTLE + 4) @(negedge clk);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        int n;
        rst_n         = 1'b0;
        pad_sel_rst_n = 1'b1;
        pad_sel_inc   = 1'b0;
        pad_sel_ena   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_sel", int'(spine_sel), 0);
        check("reset_ena", int'(spine_ena), 0);
        check("reset_busy", int'(busy), 0);

        p_sel  = '0;
        p_ena  = 1'b0;
        p_bsy  = 1'b0;
        mon_en = 1'b1;
        rst_n  = 1'b1;
        n = cyc;
        push_ev(0, 1'b1, 1'b0, n + ENA_LAT);
        repeat (8) @(negedge clk);

        for (int k = 0; k < 5; k++) step_clean();
        repeat (6) @(negedge clk);

        fast_incs(1018);
        step_clean();
        repeat (6) @(negedge clk);

        fast_incs(7);
        n = cyc;
        pad_sel_rst_n = 1'b0;
        pad_sel_inc   = 1'b1;
        m_sel = 0;
        push_ev(0, 1'b0, 1'b1, n + 3);
        push_ev(0, 1'b1, 1'b0, n + 3 + SETTLE);
        repeat (12) @(negedge clk);
        pad_sel_rst_n = 1'b1;
        pad_sel_inc   = 1'b0;
        repeat (14) @(negedge clk);

        n = cyc;
        push_ev(1, 1'b0, 1'b1, n + LAT);
        drive_inc(R_HI, R_LO);
        m_sel = 2;
        push_ev(2, 1'b0, 1'b1, n + R_GAP + LAT);
        push_ev(2, 1'b1, 1'b0, n + R_GAP + LAT + SETTLE);
        drive_inc(6, 6);
        repeat (14) @(negedge clk);

        n = cyc;
        if (DEB == 0) begin
            m_sel = m_sel + 1;
            push_ev(m_sel, 1'b0, 1'b1, n + LAT);
            push_ev(m_sel, 1'b1, 1'b0, n + LAT + SETTLE);
        end
        drive_inc(2, 14);
        repeat (4) @(negedge clk);

        n = cyc;
        pad_sel_ena = 1'b0;
        push_ev(m_sel, 1'b0, 1'b0, n + ENA_LAT);
        repeat (6) @(negedge clk);
        n = cyc;
        m_sel = m_sel + 1;
        push_ev(m_sel, 1'b0, 1'b1, n + LAT);
        push_ev(m_sel, 1'b0, 1'b0, n + LAT + SETTLE);
        drive_inc(6, 12);
        n = cyc;
        pad_sel_ena = 1'b1;
        push_ev(m_sel, 1'b1, 1'b0, n + ENA_LAT);
        repeat (10) @(negedge clk);

        check("final_sel", int'(spine_sel), m_sel);
        check("final_branch", int'(sel_branch(spine_sel)), int'(sel_branch(ADDR_W'(m_sel))));
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
